// File: rtl/mode_sequencer_if.sv
// rtl/mode_sequencer_if.sv - control and status bundle between the mode sequencer and its neighbours
interface mode_sequencer_if #(
  parameter int KV = 30,
  parameter int LW = 11
);
  localparam int RW = (KV > 1) ? $clog2(KV) : 1;

  logic          vs_i;
  logic          de_i;
  logic          next_i;
  logic          flip_i;
  logic          bypass_i;
  logic [2:0]    mode_o;
  logic [2:0]    req_o;
  logic          pending_o;
  logic [RW-1:0] row_o;
  logic          freeze_o;
  logic [LW-1:0] line_o;
  logic          frame_ok_o;
  logic [3:0]    led_o;

  // The sequencer itself
  modport slave (
    input  vs_i, de_i, next_i, flip_i, bypass_i,
    output mode_o, req_o, pending_o, row_o, freeze_o, line_o, frame_ok_o, led_o
  );

  // Whoever drives sync, buttons and consumes the status
  modport master (
    output vs_i, de_i, next_i, flip_i, bypass_i,
    input  mode_o, req_o, pending_o, row_o, freeze_o, line_o, frame_ok_o, led_o
  );
endinterface

// File: rtl/mode_sequencer.sv
// rtl/mode_sequencer.sv - frame-synchronous mode commit, block-row cursor and frame height check
module mode_sequencer #(
  parameter int KV = 30,
  parameter int VP = 1080,
  parameter int LW = 11
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  mode_sequencer_if.slave  bus
);
  localparam int            RW         = (KV > 1) ? $clog2(KV) : 1;
  localparam logic [RW-1:0] ROW_LAST   = RW'(KV - 1);
  localparam logic [LW-1:0] LINE_MAX   = '1;
  localparam logic [LW-1:0] LINE_GOOD  = LW'(VP);
  localparam logic [2:0]    MODE_DIR   = 3'd0;
  localparam logic [2:0]    MODE_RESET = 3'd2;

  logic [2:0]    req_q, req_d;
  logic [2:0]    mode_q, mode_d;
  logic          pending_q, pending_d;
  logic [RW-1:0] row_q, row_d;
  logic [LW-1:0] line_q, line_d;
  logic          frame_ok_q, frame_ok_d;
  logic          vs_r_q, vs_r_d;
  logic          de_r_q, de_r_d;
  logic          commit;
  logic          de_fall;

  // Frame boundary and end-of-line events
  always_comb begin
    commit  = bus.vs_i & ~vs_r_q;
    de_fall = de_r_q & ~bus.de_i;
  end

  // Request/commit path: the commit latches the pre-pulse request, a same-cycle pulse re-arms pending
  always_comb begin
    req_d     = req_q;
    mode_d    = mode_q;
    pending_d = pending_q;
    if (commit) begin
      mode_d    = bus.bypass_i ? MODE_DIR : req_q;
      pending_d = 1'b0;
    end
    if (bus.next_i) begin
      req_d     = {req_q[2:1] + 2'd1, req_q[0]};
      pending_d = 1'b1;
    end else if (bus.flip_i) begin
      req_d     = req_q ^ 3'd1;
      pending_d = 1'b1;
    end
  end

  // Line tracking: vsync parks the cursor and masks line ends; the commit closes the frame count
  always_comb begin
    vs_r_d     = bus.vs_i;
    de_r_d     = bus.vs_i ? 1'b0 : bus.de_i;
    row_d      = row_q;
    line_d     = line_q;
    frame_ok_d = frame_ok_q;
    if (bus.vs_i) begin
      row_d = '0;
    end else if (de_fall) begin
      row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      if (line_q != LINE_MAX) begin
        line_d = line_q + 1'b1;
      end
    end
    if (commit) begin
      frame_ok_d = (line_q == LINE_GOOD);
      line_d     = '0;
    end
  end

  // State register; vs_r resets high so releasing reset inside vsync cannot commit
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_q      <= MODE_RESET;
      mode_q     <= MODE_RESET;
      pending_q  <= 1'b0;
      row_q      <= '0;
      line_q     <= '0;
      frame_ok_q <= 1'b0;
      vs_r_q     <= 1'b1;
      de_r_q     <= 1'b0;
    end else begin
      req_q      <= req_d;
      mode_q     <= mode_d;
      pending_q  <= pending_d;
      row_q      <= row_d;
      line_q     <= line_d;
      frame_ok_q <= frame_ok_d;
      vs_r_q     <= vs_r_d;
      de_r_q     <= de_r_d;
    end
  end

  // Status outputs straight from the registers
  always_comb begin
    bus.mode_o     = mode_q;
    bus.req_o      = req_q;
    bus.pending_o  = pending_q;
    bus.row_o      = row_q;
    bus.freeze_o   = (row_q == ROW_LAST);
    bus.line_o     = line_q;
    bus.frame_ok_o = frame_ok_q;
    bus.led_o      = {pending_q, mode_q};
  end
endmodule

// File: tb/tb_mode_sequencer.sv
// tb/tb_mode_sequencer.sv - directed and random checks of mode_sequencer against a reference model
module tb_mode_sequencer;
  localparam int KV       = 30;
  localparam int VP       = 1080;
  localparam int LW       = 11;
  localparam int LINE_MAX = (1 << LW) - 1;

  logic clk_i = 1'b0;
  logic rst_ni;

  always #5 clk_i = ~clk_i;

  mode_sequencer_if #(.KV(KV), .LW(LW)) bus ();

  mode_sequencer #(.KV(KV), .VP(VP), .LW(LW)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  // reference model state
  int m_req, m_mode, m_pend, m_row, m_line, m_ok, p_vs, p_de;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_req = 2; m_mode = 2; m_pend = 0;
    m_row = 0; m_line = 0; m_ok = 0;
    p_vs = 1;  p_de = 0;
  endtask

  task automatic model_clock(input bit v, input bit d, input bit n, input bit f, input bit b);
    if (v && !p_vs) begin
      m_mode = b ? 0 : m_req;
      m_pend = 0;
      m_ok   = (m_line == VP) ? 1 : 0;
      m_line = 0;
    end
    if (n) begin
      m_req  = (m_req + 2) % 8;
      m_pend = 1;
    end else if (f) begin
      m_req  = (m_req % 2 == 1) ? m_req - 1 : m_req + 1;
      m_pend = 1;
    end
    if (v) begin
      m_row = 0;
      p_de  = 0;
    end else begin
      if (p_de == 1 && !d) begin
        m_row  = (m_row + 1) % KV;
        m_line = (m_line < LINE_MAX) ? m_line + 1 : LINE_MAX;
      end
      p_de = d;
    end
    p_vs = v;
  endtask

  task automatic check_all();
    check("mode", bus.mode_o, m_mode);
    check("req", bus.req_o, m_req);
    check("pending", bus.pending_o, m_pend);
    check("row", bus.row_o, m_row);
    check("freeze", bus.freeze_o, (m_row == KV - 1) ? 1 : 0);
    check("line", bus.line_o, m_line);
    check("frame_ok", bus.frame_ok_o, m_ok);
    check("led", bus.led_o, m_pend * 8 + m_mode);
  endtask

  task automatic step(input bit v, input bit d, input bit n, input bit f, input bit b);
    @(negedge clk_i);
    bus.vs_i = v; bus.de_i = d; bus.next_i = n; bus.flip_i = f; bus.bypass_i = b;
    @(posedge clk_i);
    if (!rst_ni) model_reset();
    else model_clock(v, d, n, f, b);
    #1;
    bus.next_i = 1'b0;
    bus.flip_i = 1'b0;
    check_all();
  endtask

  task automatic lines(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic vsync(input bit b);
    step(1'b1, 1'b0, 1'b0, 1'b0, b);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic async_reset_check();
    rst_ni = 1'b0;
    #1;
    model_reset();
    check_all();
    check("rst_req", bus.req_o, 2);
    check("rst_mode", bus.mode_o, 2);
    check("rst_row", bus.row_o, 0);
    check("rst_line", bus.line_o, 0);
    check("rst_led", bus.led_o, 4'b0010);
  endtask

  initial begin
    bit v, d, n, f, b;
    rst_ni = 1'b0;
    bus.vs_i = 1'b1; bus.de_i = 1'b0; bus.next_i = 1'b0; bus.flip_i = 1'b0; bus.bypass_i = 1'b0;
    model_reset();

    // reset, then release during vsync: no commit
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("init_led", bus.led_o, 4'b0010);
    check("init_frame_ok", bus.frame_ok_o, 0);
    rst_ni = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rel_vs_mode", bus.mode_o, 2);
    check("rel_vs_pend", bus.pending_o, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    lines(5);

    // next then commit
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("next_req", bus.req_o, 4);
    check("next_pend", bus.pending_o, 1);
    check("next_mode_hold", bus.mode_o, 2);
    lines(3);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("commit_mode", bus.mode_o, 4);
    check("commit_pend", bus.pending_o, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("nnf_req", bus.req_o, 1);

    // asynchronous reset in the middle of a line
    lines(2);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    async_reset_check();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_ni = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // simultaneous pulses and a pulse in the commit cycle
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("both_req", bus.req_o, 4);
    lines(2);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("cflip_mode", bus.mode_o, 4);
    check("cflip_req", bus.req_o, 5);
    check("cflip_pend", bus.pending_o, 1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // cursor wrap over 31 lines, then vsync mid-frame parks it
    for (int i = 1; i <= 31; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("wrap_row", bus.row_o, i % KV);
      check("wrap_freeze", bus.freeze_o, (i % KV == KV - 1) ? 1 : 0);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("vs_row", bus.row_o, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // frame heights
    lines(VP);
    vsync(1'b0);
    check("h1080_ok", bus.frame_ok_o, 1);
    lines(VP - 1);
    vsync(1'b0);
    check("h1079_ok", bus.frame_ok_o, 0);
    lines(2100);
    check("h2100_sat", bus.line_o, LINE_MAX);
    vsync(1'b0);
    check("h2100_ok", bus.frame_ok_o, 0);
    check("h2100_line_clr", bus.line_o, 0);

    // bypass forces DIRECT at commit only
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("byp_req_pre", bus.req_o, 6);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("byp_mode", bus.mode_o, 0);
    check("byp_req", bus.req_o, 6);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("byp_idle_mode", bus.mode_o, 0);
    lines(2);
    vsync(1'b0);
    check("unbyp_mode", bus.mode_o, 6);

    // randomized traffic with a mid-run reset
    b = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        async_reset_check();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_ni = 1'b1;
      end
      v = ($urandom_range(0, 99) < 3);
      d = $urandom_range(0, 1) == 1;
      n = ($urandom_range(0, 15) == 0);
      f = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 31) == 0) b = ~b;
      step(v, d, n, f, b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mode_sequencer.md
# mode_sequencer

Frame-synchronous controller for the inversion datapath. It turns button pulses into an operating-mode request and commits that request only at a frame boundary, so the output never changes mode mid-frame. It also generates the KV-line block-row cursor and the freeze strobe used by the block and line buffers, and checks the incoming frame height. It sits in the `vin_clk_i` domain, between the button debouncer and the buffers/output mix.

## Interface
Parameters:
- `KV`, 30: lines per block row; the cursor wraps at KV-1.
- `VP`, 1080: expected active lines per frame.
- `LW`, 11: width of the line counter.

Ports:
- `clk_i` in 1: video pixel clock.
- `rst_ni` in 1: asynchronous, active-low reset.
- `vs_i` in 1: registered vertical sync, active-high.
- `de_i` in 1: registered data enable.
- `next_i` in 1: single-cycle pulse that advances the algorithm (DIRECT→BLK→LIN→FRM→DIRECT, preserving the dark/light polarity).
- `flip_i` in 1: single-cycle pulse that toggles the dark/light polarity.
- `bypass_i` in 1: level input; when sampled high at commit, the committed mode is forced to DIRECT.
- `mode_o` out 3: committed mode, driven from a register.
- `req_o` out 3: requested mode, driven from a register.
- `pending_o` out 1: high when the request is newer than the last commit.
- `row_o` out clog2(KV): block-row cursor.
- `freeze_o` out 1: equals (`row_o` == KV-1); combinational from the `row_o` register.
- `line_o` out LW: active-line count in the current frame.
- `frame_ok_o` out 1: high when the previous frame had exactly VP lines.
- `led_o` out 4: {`pending_o`, `mode_o`}.

## Operation
Mode encodings:
- 0 DIRECT, 1 INV, 2 BLK_DARK, 3 BLK_LIGHT, 4 LIN_DARK, 5 LIN_LIGHT, 6 FRM_DARK, 7 FRM_LIGHT.

Request register:
- `next_i`: 0→2→4→6→0 and 1→3→5→7→1.
- `flip_i`: toggles bit 0 (0↔1, 2↔3, 4↔5, 6↔7).
- `next_i` and `flip_i` in the same cycle: `next_i` wins, `flip_i` is dropped.
- Any accepted pulse sets `pending_o`.

Commit:
- A commit occurs on the vs rising edge, i.e. the cycle where `vs_i`=1 and the internal `vs_r`=0.
- At commit: `mode_o` <= `bypass_i` ? 0 : `req_o`; `pending_o` <= 0.
- A pulse arriving in the commit cycle is applied to `req_o`. `mode_o` takes the pre-pulse `req_o`, and `pending_o` ends at 1.
- `bypass_i` has no effect outside commit cycles.

Line tracking:
- `de_r` holds the previous `de_i`. A falling edge is `de_r`=1 and `de_i`=0.
- On a falling edge, `row_o` <= (`row_o`==KV-1) ? 0 : `row_o`+1.
- On a falling edge, `line_o` <= `line_o`+1, saturating at 2^LW-1.
- While `vs_i`=1: `row_o` <= 0, `de_r` <= 0, and `line_o` holds its value.
- At commit: `frame_ok_o` <= (`line_o`==VP); `line_o` <= 0.
- Lines completed while `vs_i` is high are not counted.

Reset values (asynchronous, immediate):
- `req_o`=2, `mode_o`=2, `pending_o`=0.
- `row_o`=0, `line_o`=0, `frame_ok_o`=0, `vs_r`=1, `de_r`=0.
- `led_o`=4'b0010.
- `vs_r`=1 ensures that the first commit never fires if reset is released during vsync.

Reset mid-frame:
- All state is cleared immediately.
- The next frame's count is partial, so `frame_ok_o` reads 0 after the following commit unless that frame is complete.

## Timing
- All outputs except `freeze_o` are registered, with 1-cycle latency from the causing input edge.
- `mode_o` changes the cycle after the first `vs_i`=1 cycle.
- `row_o` and `line_o` change the cycle after the first `de_i`=0 cycle.
- `freeze_o` rises in the same cycle that `row_o` becomes KV-1.
- No handshake: pulses are assumed to be one cycle wide, and every pulse is acted on.
- The pulse inputs come from the debouncer in the same clock domain; no synchronizer is needed.

## Test plan
- **Reset:** assert `rst_ni`=0 mid-line → all outputs are at their reset values within the same cycle. Release `rst_ni` during `vs_i`=1 → no commit occurs; `mode_o`=2.
- **Next and commit:** `next_i` pulse mid-frame → `req_o`=4, `pending_o`=1, `mode_o` stays 2. At the next vs rising edge → `mode_o`=4, `pending_o`=0. A further `next_i` ×2 then `flip_i` → `req_o`=1.
- **Simultaneous pulses:** `next_i` and `flip_i` in the same cycle from 2 → `req_o`=4. A `flip_i` pulse in the commit cycle with `req_o`=4 → `mode_o`=4, `req_o`=5, `pending_o`=1.
- **Cursor wrap:** 31 DE pulses → `row_o` sequence 0..29,0,1. `freeze_o` is high exactly while `row_o`=29. `vs_i` high mid-frame → `row_o`=0.
- **Frame height:** frame of 1080 lines → `frame_ok_o`=1 after commit. Frame of 1079 → 0. Frame of 2100 → `line_o` saturates at 2047 and `frame_ok_o`=0.
- **Bypass:** `bypass_i`=1 at commit with `req_o`=6 → `mode_o`=0 and `req_o` stays 6. Release `bypass_i`, next commit → `mode_o`=6.
